// File: rtl/axil_ram_scrubber.sv
// axil_ram_scrubber: AXI4-Lite master that fills and/or checks a RAM word range with a seed^index pattern.
module axil_ram_scrubber #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = ADDR_WIDTH - $clog2(DATA_WIDTH / 8) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  word_count_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr_o,
  output logic                  m_axil_awvalid_o,
  input  logic                  m_axil_awready_i,
  output logic [DATA_WIDTH-1:0] m_axil_wdata_o,
  output logic                  m_axil_wvalid_o,
  input  logic                  m_axil_wready_i,
  input  logic [1:0]            m_axil_bresp_i,
  input  logic                  m_axil_bvalid_i,
  output logic                  m_axil_bready_o,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr_o,
  output logic                  m_axil_arvalid_o,
  input  logic                  m_axil_arready_i,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata_i,
  input  logic [1:0]            m_axil_rresp_i,
  input  logic                  m_axil_rvalid_i,
  output logic                  m_axil_rready_o
);
  localparam int LG = $clog2(DATA_WIDTH / 8);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t                state_q;
  logic [CNT_WIDTH-1:0]  k_q, cnt_q, k_d;
  logic [ADDR_WIDTH-1:0] base_q, base_al, addr_d, err_addr_q, awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] seed_q, pat_d, wdata_q;
  logic chk_q, aw_done_q, w_done_q, last_d, aw_ok, w_ok, rd_bad;
  logic busy_q, done_q, err_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  assign base_al = base_addr_i & ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
  assign k_d     = k_q + CNT_WIDTH'(1);
  assign last_d  = k_d == cnt_q;
  assign addr_d  = base_q + (ADDR_WIDTH'(k_d) << LG);
  assign pat_d   = seed_q ^ DATA_WIDTH'(k_d);
  assign aw_ok   = aw_done_q | m_axil_awready_i;
  assign w_ok    = w_done_q | m_axil_wready_i;
  assign rd_bad  = m_axil_rresp_i != 2'b00 || m_axil_rdata_i != (seed_q ^ DATA_WIDTH'(k_q));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      seed_q     <= '0;
      chk_q      <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      araddr_q   <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          chk_q      <= mode_i[1];
          cnt_q      <= word_count_i;
          seed_q     <= seed_i;
          base_q     <= base_al;
          k_q        <= '0;
          err_q      <= 1'b0;
          err_addr_q <= '0;
          aw_done_q  <= 1'b0;
          w_done_q   <= 1'b0;
          if (mode_i == 2'b00 || word_count_i == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (mode_i[0]) begin
            state_q   <= WR_REQ;
            busy_q    <= 1'b1;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= base_al;
            wdata_q   <= seed_i;
          end else begin
            state_q   <= RD_REQ;
            busy_q    <= 1'b1;
            arvalid_q <= 1'b1;
            araddr_q  <= base_al;
          end
        end
        WR_REQ: begin
          if (m_axil_awready_i) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (m_axil_wready_i) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_ok && w_ok) begin
            state_q   <= WR_RESP;
            bready_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        WR_RESP: if (m_axil_bvalid_i) begin
          bready_q <= 1'b0;
          if (m_axil_bresp_i != 2'b00) begin
            if (!err_q) err_addr_q <= awaddr_q;
            err_q <= 1'b1;
          end
          k_q <= k_d;
          if (!last_d) begin
            state_q   <= WR_REQ;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= addr_d;
            wdata_q   <= pat_d;
          end else if (chk_q) begin
            state_q   <= RD_REQ;
            k_q       <= '0;
            arvalid_q <= 1'b1;
            araddr_q  <= base_q;
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        RD_REQ: if (m_axil_arready_i) begin
          state_q   <= RD_RESP;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
        end
        RD_RESP: if (m_axil_rvalid_i) begin
          rready_q <= 1'b0;
          if (rd_bad) begin
            if (!err_q) err_addr_q <= araddr_q;
            err_q <= 1'b1;
          end
          k_q <= k_d;
          if (last_d) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= RD_REQ;
            arvalid_q <= 1'b1;
            araddr_q  <= addr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign err_addr_o       = err_addr_q;
  assign m_axil_awaddr_o  = awaddr_q;
  assign m_axil_awvalid_o = awvalid_q;
  assign m_axil_wdata_o   = wdata_q;
  assign m_axil_wvalid_o  = wvalid_q;
  assign m_axil_bready_o  = bready_q;
  assign m_axil_araddr_o  = araddr_q;
  assign m_axil_arvalid_o = arvalid_q;
  assign m_axil_rready_o  = rready_q;
endmodule

// File: tb/tb_axil_ram_scrubber.sv
// tb_axil_ram_scrubber: directed tests of the scrubber against a behavioural AXI4-Lite RAM with
// programmable ready delays and write-error injection.
module tb_axil_ram_scrubber;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int CW = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start = 1'b0;
  logic [1:0] mode = '0;
  logic [AW-1:0] base = '0;
  logic [CW-1:0] cnt = '0;
  logic [DW-1:0] seed = '0;
  logic busy, done, err, awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] err_addr, awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [1:0] bresp, rresp;
  int vectors = 0;
  int miscompares = 0;

  axil_ram_scrubber #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .base_addr_i(base),
    .word_count_i(cnt), .seed_i(seed), .busy_o(busy), .done_o(done), .err_o(err),
    .err_addr_o(err_addr), .m_axil_awaddr_o(awaddr), .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready), .m_axil_wdata_o(wdata), .m_axil_wvalid_o(wvalid),
    .m_axil_wready_i(wready), .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid),
    .m_axil_bready_o(bready), .m_axil_araddr_o(araddr), .m_axil_arvalid_o(arvalid),
    .m_axil_arready_i(arready), .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp),
    .m_axil_rvalid_i(rvalid), .m_axil_rready_o(rready)
  );

  // Behavioural RAM slave; readys are combinational once a valid has waited its delay.
  int aw_dly = 0, w_dly = 0, aw_age, w_age, vcount;
  logic aw_got, w_got;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d;
  logic [AW-1:0] bad_waddr = '1;
  logic [DW-1:0] mem [0:16383];
  logic [AW-1:0] wlog_a[$], rlog_a[$];
  logic [DW-1:0] wlog_d[$];
  assign awready = awvalid && aw_age >= aw_dly;
  assign wready  = wvalid && w_age >= w_dly;
  assign arready = arvalid;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_age <= 0; w_age <= 0; aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0;
      bvalid <= 1'b0; bresp <= '0; rvalid <= 1'b0; rresp <= '0; rdata <= '0; vcount <= 0;
    end else begin
      logic ha, hw, ga, gw;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      ha = awvalid && awready;
      hw = wvalid && wready;
      ga = aw_got || ha;
      gw = w_got || hw;
      a = ha ? awaddr : aw_a;
      d = hw ? wdata : w_d;
      if (awvalid && !awready) aw_age <= aw_age + 1;
      if (wvalid && !wready) w_age <= w_age + 1;
      if (ha) aw_age <= 0;
      if (hw) w_age <= 0;
      if (awvalid || wvalid || arvalid) vcount <= vcount + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      if (rvalid && rready) rvalid <= 1'b0;
      if (ga && gw) begin
        mem[a[AW-1:2]] = d;
        wlog_a.push_back(a);
        wlog_d.push_back(d);
        bvalid <= 1'b1;
        bresp <= (a == bad_waddr) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end else begin
        aw_got <= ga; w_got <= gw; aw_a <= a; w_d <= d;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata <= mem[araddr[AW-1:2]];
        rresp <= 2'b00;
        rlog_a.push_back(araddr);
      end
    end
  end

  task automatic start_op(input logic [1:0] m, input logic [AW-1:0] b, input logic [CW-1:0] c,
                          input logic [DW-1:0] s);
    wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
    @(negedge clk);
    mode = m; base = b; cnt = c; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int gaps);
    cyc = 0; gaps = 0;
    while (!done && cyc < 1000) begin
      if (!busy) gaps++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({busy, done, err, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
      miscompares++; $display("FAIL reset_ctl: got %b want 00000000", {busy, done, err, awvalid, wvalid, bready, arvalid, rready});
    end
    vectors++;
    if ({err_addr, awaddr, araddr, wdata} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h %h %h %h want zeros", err_addr, awaddr, araddr, wdata);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fill;
    int cyc, gaps;
    start_op(2'b01, 16'h0010, 4, 32'hA5A5_0000);
    wait_done(cyc, gaps);
    vectors++;
    if (cyc !== 8 || gaps !== 0) begin
      miscompares++; $display("FAIL fill_timing: got cyc %0d gaps %0d want 8 0", cyc, gaps);
    end
    vectors++;
    if (err !== 1'b0 || wlog_a.size() !== 4 || rlog_a.size() !== 0) begin
      miscompares++; $display("FAIL fill_count: got err %b wr %0d rd %0d want 0 4 0", err, wlog_a.size(), rlog_a.size());
    end
    for (int i = 0; i < 4 && i < wlog_a.size(); i++) begin
      vectors++;
      if (wlog_a[i] !== AW'(16'h0010 + 4 * i) || wlog_d[i] !== (32'hA5A5_0000 | DW'(i))) begin
        miscompares++; $display("FAIL fill_word%0d: got %h/%h want %h/%h", i, wlog_a[i], wlog_d[i], 16'h0010 + 4 * i, 32'hA5A5_0000 | i);
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_fill_check;
    int cyc, gaps;
    start_op(2'b11, 16'h0010, 4, 32'hA5A5_0000);
    wait_done(cyc, gaps);
    vectors++;
    if (cyc !== 16 || gaps !== 0 || err !== 1'b0) begin
      miscompares++; $display("FAIL fc_run: got cyc %0d gaps %0d err %b want 16 0 0", cyc, gaps, err);
    end
    vectors++;
    if (wlog_a.size() !== 4 || rlog_a.size() !== 4) begin
      miscompares++; $display("FAIL fc_count: got wr %0d rd %0d want 4 4", wlog_a.size(), rlog_a.size());
    end
    for (int i = 0; i < 4 && i < rlog_a.size(); i++) begin
      vectors++;
      if (rlog_a[i] !== AW'(16'h0010 + 4 * i)) begin
        miscompares++; $display("FAIL fc_raddr%0d: got %h want %h", i, rlog_a[i], 16'h0010 + 4 * i);
      end
    end
  endtask

  task automatic test_corrupt;
    int cyc, gaps;
    mem[6] = '0;
    mem[7] = '0;
    start_op(2'b10, 16'h0010, 4, 32'hA5A5_0000);
    wait_done(cyc, gaps);
    vectors++;
    if (cyc !== 8 || err !== 1'b1 || err_addr !== 16'h0018) begin
      miscompares++; $display("FAIL corrupt: got cyc %0d err %b addr %h want 8 1 0018", cyc, err, err_addr);
    end
    vectors++;
    if (rlog_a.size() !== 4 || wlog_a.size() !== 0) begin
      miscompares++; $display("FAIL corrupt_count: got rd %0d wr %0d want 4 0", rlog_a.size(), wlog_a.size());
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (err !== 1'b1 || err_addr !== 16'h0018) begin
      miscompares++; $display("FAIL err_sticky: got %b %h want 1 0018", err, err_addr);
    end
  endtask

  task automatic test_noop;
    int cyc, gaps, v0;
    v0 = vcount;
    start_op(2'b00, 16'h0010, 4, 32'h1);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
      miscompares++; $display("FAIL noop_mode: got busy %b done %b err %b want 0 1 0", busy, done, err);
    end
    start_op(2'b11, 16'h0010, 0, 32'h1);
    wait_done(cyc, gaps);
    vectors++;
    if (cyc !== 0) begin
      miscompares++; $display("FAIL noop_count: got cyc %0d want 0", cyc);
    end
    @(negedge clk);
    vectors++;
    if (vcount !== v0 || done !== 1'b0) begin
      miscompares++; $display("FAIL noop_valid: got valid cycles %0d done %b want 0 0", vcount - v0, done);
    end
  endtask

  task automatic test_wrap_delay;
    int cyc, gaps;
    w_dly = 3;
    start_op(2'b01, 16'hFFF8, 3, 32'h1234_5678);
    wait_done(cyc, gaps);
    w_dly = 0;
    vectors++;
    if (cyc !== 15 || wlog_a.size() !== 3 || err !== 1'b0) begin
      miscompares++; $display("FAIL wrap_run: got cyc %0d wr %0d err %b want 15 3 0", cyc, wlog_a.size(), err);
    end
    for (int i = 0; i < 3 && i < wlog_a.size(); i++) begin
      vectors++;
      if (wlog_a[i] !== AW'(16'hFFF8 + 4 * i) || wlog_d[i] !== (32'h1234_5678 ^ DW'(i))) begin
        miscompares++; $display("FAIL wrap_word%0d: got %h/%h want %h/%h", i, wlog_a[i], wlog_d[i], AW'(16'hFFF8 + 4 * i), 32'h1234_5678 ^ i);
      end
    end
  endtask

  task automatic test_bresp;
    int cyc, gaps;
    bad_waddr = 16'h0104;
    start_op(2'b01, 16'h0102, 4, 32'h0);
    wait_done(cyc, gaps);
    bad_waddr = '1;
    vectors++;
    if (err !== 1'b1 || err_addr !== 16'h0104 || wlog_a.size() !== 4 || wlog_a[0] !== 16'h0100) begin
      miscompares++; $display("FAIL bresp: got err %b addr %h wr %0d want 1 0104 4 (first 0100)", err, err_addr, wlog_a.size());
    end
  endtask

  task automatic test_reset_mid;
    int cyc, gaps, n;
    start_op(2'b11, 16'h0010, 4, 32'h0);
    n = 0;
    while (!rready && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (rready !== 1'b1) begin
      miscompares++; $display("FAIL mid_reach: got rready %b want 1", rready);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, err, awvalid, wvalid, bready, arvalid, rready} !== 8'h00 || {err_addr, awaddr, araddr, wdata} !== '0) begin
      miscompares++; $display("FAIL mid_reset: got %b %h %h %h %h want zeros", {busy, done, err, awvalid, wvalid, bready, arvalid, rready}, err_addr, awaddr, araddr, wdata);
    end
    @(negedge clk); rst_n = 1'b1;
    start_op(2'b11, 16'h0040, 2, 32'hCAFE_0000);
    wait_done(cyc, gaps);
    vectors++;
    if (cyc !== 8 || err !== 1'b0 || wlog_a.size() !== 2 || rlog_a.size() !== 2) begin
      miscompares++; $display("FAIL post_reset: got cyc %0d err %b wr %0d rd %0d want 8 0 2 2", cyc, err, wlog_a.size(), rlog_a.size());
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_fill_check;
    test_corrupt;
    test_noop;
    test_wrap_delay;
    test_bresp;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axil_ram_scrubber.md
# axil_ram_scrubber

AXI4-Lite master sequencer that fills a word range of the team's AXI4-Lite RAM with a deterministic pattern and/or reads the range back and checks it. Sits between the system control registers and the RAM's AXI4-Lite slave port, used for memory init after power-up and for built-in self-test. Issues one transaction at a time, with no outstanding overlap. Reports completion, sticky error, and the first failing address.

## Interface
- DATA_WIDTH, 32, bus data width; multiple of 8.
- ADDR_WIDTH, 16, byte address width.
- CNT_WIDTH, ADDR_WIDTH-$clog2(DATA_WIDTH/8)+1, width of word_count.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- mode  in  2  01 fill, 10 check, 11 fill then check, 00 no-op.
- base_addr  in  ADDR_WIDTH  first byte address; low $clog2(DATA_WIDTH/8) bits forced to 0.
- word_count  in  CNT_WIDTH  number of words to process.
- seed  in  DATA_WIDTH  pattern seed.
- busy  out  1  high from cycle after accepted start until DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky mismatch/response error; cleared by next accepted start.
- err_addr  out  ADDR_WIDTH  byte address of first error.
- m_axil_awaddr  out  ADDR_WIDTH  write address.
- m_axil_awvalid  out  1  write address valid.
- m_axil_awready  in  1  write address ready.
- m_axil_wdata  out  DATA_WIDTH  write data.
- m_axil_wvalid  out  1  write data valid.
- m_axil_wready  in  1  write data ready.
- m_axil_bresp  in  2  write response.
- m_axil_bvalid  in  1  write response valid.
- m_axil_bready  out  1  write response ready.
- m_axil_araddr  out  ADDR_WIDTH  read address.
- m_axil_arvalid  out  1  read address valid.
- m_axil_arready  in  1  read address ready.
- m_axil_rdata  in  DATA_WIDTH  read data.
- m_axil_rresp  in  2  read response.
- m_axil_rvalid  in  1  read data valid.
- m_axil_rready  out  1  read data ready.
- No prot/wstrb ports: integrator ties awprot/arprot to 3'b000 and wstrb to all ones.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: on start, latch base/count/seed/mode, clear err, err_addr, index k=0. Next state: mode 00 or word_count 0 -> DONE; mode bit0 -> WR_REQ; else RD_REQ.
- Pattern word k: seed XOR k (k zero-extended). Address k: base + k*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH (wraps silently).
- WR_REQ: awvalid and wvalid asserted together in the same cycle, each held until its own handshake; track aw_done/w_done; when both done -> WR_RESP.
- WR_RESP: bready=1; on bvalid: bresp!=00 flags error at that address; k++; if k==count: mode bit1 -> RD_REQ with k=0, else DONE; otherwise WR_REQ.
- RD_REQ: arvalid held until arready -> RD_RESP.
- RD_RESP: rready=1; on rvalid: error if rresp!=00 or rdata != pattern; k++; k==count -> DONE, else RD_REQ.
- Error: err set; err_addr captured only on first error; sequence continues to end, never aborts.
- DONE: done=1, busy=0 for one cycle, then IDLE. start during busy/DONE ignored.

## Timing
- Reset values: all valids/readies 0, busy 0, done 0, err 0, err_addr 0, addresses/wdata 0, state IDLE.
- Outputs registered; valid/data change only at clock edges; address/data stable while valid high.
- Minimum with zero-wait slave: 2 cycles per write word, 2 per read word; start to busy 1 cycle.
- rst_n asserted mid-operation: immediate return to reset values; whole subsystem reset together.
- Simultaneous aw/w handshake completes in one cycle; independent handshakes accepted in either order.

## Test plan
- Fill, base 0x0010, count 4, seed 0xA5A50000 -> writes 0xA5A50000..03 to 0x10,0x14,0x18,0x1C; done pulse; err 0.
- Fill+check same params against RAM -> 4 writes then 4 reads; err 0; busy high throughout until done.
- Check after corrupting word 2 to 0 -> err 1, err_addr 0x0018; all 4 reads still issued.
- Count 0 or mode 00 -> done one cycle after start, no valid ever asserted.
- base 0xFFF8, count 3 -> addresses 0xFFF8, 0xFFFC, 0x0000; slave delays wready 3 cycles after awready -> single write per word, correct data.
- rst_n low during RD_RESP -> all outputs at reset values immediately; new start after release runs normally.
